object_fifo: RTL and testbench

Parametrised first-word-fall-through queue of parsed-field table entries, successor to the single-write object buffer. Sits between the fetch stage, which produces one entry per decoded field descriptor, and the downstream serializer/consumer. Adds configurable width and depth, a pop side with fall-through output, simultaneous push/pop, almost-full back-pressure, flush, and sticky overflow/underflow flags.

---
 rtl/object_fifo_pkg.sv | 11 +
 rtl/object_fifo.sv | 97 +++++++++
 tb/tb_object_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/object_fifo_pkg.sv
// Shared types for the fetch -> consumer parsed-field path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package object_fifo_pkg;

    localparam int TABLE_ENTRY_W  = 128;
    localparam int OBJ_FIFO_DEPTH = 8;

    typedef logic [TABLE_ENTRY_W-1:0] TABLE_ENTRY;

endpackage

// File: rtl/object_fifo.sv
// FWFT queue of parsed-field table entries between fetch and the consumer.
// Latency: entry pushed at edge N is on out_entry in the cycle after edge N.
// Backpressure: full/almost_full from registered count; push into full accepted only with a same-cycle pop.
module object_fifo
    import object_fifo_pkg::*;
#(
    parameter int WIDTH     = TABLE_ENTRY_W,
    parameter int DEPTH     = OBJ_FIFO_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] new_entry,
    input  logic             valid_in,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] out_entry,
    output logic             valid_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count >= CNT_W'(AF_THRESH));
    assign valid_out   = !empty;
    assign out_entry   = mem[rd_ptr];

    assign push_ok = valid_in && (!full || pop) && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a flush cycle never raises them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (valid_in && full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_object_fifo.sv
// Drives a DEPTH=8 and a DEPTH=5 object_fifo with the same stimulus and checks both against queue models.
module tb_object_fifo;

    localparam logic [127:0] LIT = 128'h0000000940180008_0000000000000000;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] new_entry;
    logic         valid_in, pop, flush;

    logic [127:0] oe [2];
    logic         vo [2], fu [2], em [2], af [2], ov [2], un [2];
    logic [3:0]   cnt8;
    logic [2:0]   cnt5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    object_fifo u_d8 (
        .clk(clk), .reset(reset), .new_entry(new_entry), .valid_in(valid_in),
        .pop(pop), .flush(flush), .out_entry(oe[0]), .valid_out(vo[0]),
        .full(fu[0]), .empty(em[0]), .almost_full(af[0]), .count(cnt8),
        .overflow(ov[0]), .underflow(un[0])
    );

    object_fifo #(.DEPTH(5)) u_d5 (
        .clk(clk), .reset(reset), .new_entry(new_entry), .valid_in(valid_in),
        .pop(pop), .flush(flush), .out_entry(oe[1]), .valid_out(vo[1]),
        .full(fu[1]), .empty(em[1]), .almost_full(af[1]), .count(cnt5),
        .overflow(ov[1]), .underflow(un[1])
    );

    // Reference model: a plain queue per instance plus sticky flags.
    int           mdepth [2] = '{8, 5};
    int           mthr   [2] = '{6, 3};
    logic [127:0] mq [2][$];
    bit           movf [2];
    bit           munf [2];

    task automatic model_step(input int i);
        bit is_full, is_empty;
        if (flush) begin
            mq[i].delete();
            return;
        end
        is_full  = (mq[i].size() == mdepth[i]);
        is_empty = (mq[i].size() == 0);
        if (valid_in && is_full && !pop) movf[i] = 1'b1;
        if (pop && is_empty) munf[i] = 1'b1;
        if (pop && !is_empty) void'(mq[i].pop_front());
        if (valid_in && (!is_full || pop)) mq[i].push_back(new_entry);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                movf[i] = 1'b0;
                munf[i] = 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_count(input int i);
        return (i == 0) ? int'(cnt8) : int'(cnt5);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int sz;
            sz = mq[i].size();
            check($sformatf("d%0d.count", mdepth[i]), 128'(dut_count(i)), 128'(sz));
            check($sformatf("d%0d.empty", mdepth[i]), 128'(em[i]), 128'(sz == 0));
            check($sformatf("d%0d.full", mdepth[i]), 128'(fu[i]), 128'(sz == mdepth[i]));
            check($sformatf("d%0d.valid_out", mdepth[i]), 128'(vo[i]), 128'(sz != 0));
            check($sformatf("d%0d.almost_full", mdepth[i]), 128'(af[i]), 128'(sz >= mthr[i]));
            check($sformatf("d%0d.overflow", mdepth[i]), 128'(ov[i]), 128'(movf[i]));
            check($sformatf("d%0d.underflow", mdepth[i]), 128'(un[i]), 128'(munf[i]));
            if (sz != 0) check($sformatf("d%0d.out_entry", mdepth[i]), oe[i], mq[i][0]);
        end
    end

    task automatic cyc(input bit vi, input bit pp, input bit fl, input logic [127:0] d);
        valid_in  = vi;
        pop       = pp;
        flush     = fl;
        new_entry = d;
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        valid_in = 1'b0; pop = 1'b0; flush = 1'b0; new_entry = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst.empty", 128'(em[0]), 128'd1);
        check("rst.count", 128'(cnt8), 128'd0);
        check("rst.valid_out", 128'(vo[0]), 128'd0);
        check("rst.full", 128'(fu[0]), 128'd0);
        check("rst.almost_full", 128'(af[0]), 128'd0);
        check("rst.flags", 128'({ov[0], un[0]}), 128'd0);

        // Single push, fall-through next cycle, then pop
        cyc(1, 0, 0, LIT);
        check("push1.out_entry", oe[0], LIT);
        check("push1.valid_out", 128'(vo[0]), 128'd1);
        check("push1.count", 128'(cnt8), 128'd1);
        cyc(0, 1, 0, '0);
        check("pop1.empty", 128'(em[0]), 128'd1);
        check("pop1.count", 128'(cnt8), 128'd0);

        // Fill DEPTH=8 with 0..7; almost_full from count 6
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 0, 128'(k));
            check("fill.almost_full", 128'(af[0]), 128'(k + 1 >= 6));
        end
        check("fill.full", 128'(fu[0]), 128'd1);
        check("fill.count", 128'(cnt8), 128'd8);
        check("fill.d5_full", 128'(fu[1]), 128'd1);

        // Full with push+pop: head out, tail in, no overflow
        cyc(1, 1, 0, 128'd8);
        check("fullpp.count", 128'(cnt8), 128'd8);
        check("fullpp.head", oe[0], 128'd1);
        check("fullpp.overflow", 128'(ov[0]), 128'd0);

        // Push into full without pop is dropped
        cyc(1, 0, 0, 128'd99);
        check("ovf.overflow", 128'(ov[0]), 128'd1);
        check("ovf.count", 128'(cnt8), 128'd8);

        for (int k = 1; k <= 8; k++) begin
            check("drain.order", oe[0], 128'(k));
            cyc(0, 1, 0, '0);
        end
        check("drain.empty", 128'(em[0]), 128'd1);

        // Underflow, then push+pop on empty
        cyc(0, 1, 0, '0);
        check("unf.underflow", 128'(un[0]), 128'd1);
        check("unf.count", 128'(cnt8), 128'd0);
        cyc(1, 1, 0, 128'd200);
        check("emptypp.count", 128'(cnt8), 128'd1);
        check("emptypp.out_entry", oe[0], 128'd200);

        // Flush with three entries and a concurrent push
        cyc(1, 0, 0, 128'd201);
        cyc(1, 0, 0, 128'd202);
        check("preflush.count", 128'(cnt8), 128'd3);
        cyc(1, 0, 1, 128'd300);
        check("flush.count", 128'(cnt8), 128'd0);
        check("flush.empty", 128'(em[0]), 128'd1);
        check("flush.flags_kept", 128'({ov[0], un[0]}), 128'd3);

        // Async reset between edges
        cyc(1, 0, 0, 128'd400);
        cyc(1, 0, 0, 128'd401);
        valid_in = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("arst.count", 128'(cnt8), 128'd0);
        check("arst.empty", 128'(em[0]), 128'd1);
        check("arst.flags", 128'({ov[0], un[0], ov[1], un[1]}), 128'd0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized phases with varying push/pop bias
        for (int ph = 0; ph < 6; ph++) begin
            int pv, pp_w;
            pv   = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 25;
            pp_w = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 50 : 75;
            for (int c = 0; c < 400; c++) begin
                cyc($urandom_range(99) < pv, $urandom_range(99) < pp_w,
                    $urandom_range(59) == 0, rnd128());
            end
        end

        cyc(0, 0, 0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
